// File: rtl/deser_queue_gen.sv
// deser_queue_gen: bit-serial deserializer feeding a DEPTH-entry circular word queue.
// Define DESER_PARITY_EN to add a trailing even-parity bit check per word.
module deser_queue_gen #(
  parameter int WORD_W    = 8,
  parameter int DEPTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clock_1MHz,
  input  logic                         rst,
  input  logic                         data_in,
  input  logic                         write_in,
  input  logic                         dequeue_in,
  output logic                         status_out,
  output logic [WORD_W-1:0]            data_out,
  output logic [$clog2(DEPTH+1)-1:0]   len_out,
  output logic                         full_out,
  output logic                         empty_out,
  output logic                         overflow_out
`ifdef DESER_PARITY_EN
  ,
  output logic                         parity_err_out
`endif
);

  localparam int CW = $clog2(WORD_W);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    COLLECT,
`ifdef DESER_PARITY_EN
    PARITY,
`endif
    PUSH,
    WAIT_SPACE
  } state_t;

  state_t            state, state_nxt;
  logic              write_q, deq_q;
  logic              write_edge, deq_edge;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic              last_bit;
  logic              do_shift, do_push, do_pop;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     count;
`ifdef DESER_PARITY_EN
  logic              par_fail;
`endif

  // Edge copies reset high so strobes held across reset release are ignored.
  assign write_edge = write_in & ~write_q;
  assign deq_edge   = dequeue_in & ~deq_q;
  assign last_bit   = (bit_cnt == CW'(WORD_W-1));

  assign full_out   = (count == LW'(DEPTH));
  assign empty_out  = (count == '0);
  assign len_out    = count;
  assign data_out   = empty_out ? '0 : mem[rd_ptr];
  assign status_out = (state != PUSH) && (state != WAIT_SPACE);
  assign do_pop     = deq_edge && !empty_out;

  always_ff @(posedge clock_1MHz) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_shift  = 1'b0;
    do_push   = 1'b0;
`ifdef DESER_PARITY_EN
    par_fail  = 1'b0;
`endif
    case (state)
      COLLECT: begin
        if (write_edge) begin
          do_shift = 1'b1;
`ifdef DESER_PARITY_EN
          if (last_bit) state_nxt = PARITY;
`else
          if (last_bit) state_nxt = PUSH;
`endif
        end
      end
`ifdef DESER_PARITY_EN
      PARITY: begin
        if (write_edge) begin
          if (^{shreg, data_in}) begin
            par_fail  = 1'b1;
            state_nxt = COLLECT;
          end else begin
            state_nxt = PUSH;
          end
        end
      end
`endif
      PUSH: begin
        if (full_out) begin
          state_nxt = WAIT_SPACE;
        end else begin
          do_push   = 1'b1;
          state_nxt = COLLECT;
        end
      end
      WAIT_SPACE: begin
        if (!full_out) begin
          do_push   = 1'b1;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      write_q      <= 1'b1;
      deq_q        <= 1'b1;
      shreg        <= '0;
      bit_cnt      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_out <= 1'b0;
`endif
    end else begin
      write_q <= write_in;
      deq_q   <= dequeue_in;
      if (do_shift) begin
        shreg   <= (MSB_FIRST != 0) ? {shreg[WORD_W-2:0], data_in}
                                    : {data_in, shreg[WORD_W-1:1]};
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      if (write_edge && !status_out) overflow_out <= 1'b1;
`ifdef DESER_PARITY_EN
      if (par_fail) parity_err_out <= 1'b1;
`endif
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_1MHz) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

endmodule

// File: tb/tb_deser_queue_gen.sv
// Scoreboard bench for deser_queue_gen: MSB-first and LSB-first instances share stimulus;
// words are predicted in arrival order and checked by a consumer process as they appear.
module tb_deser_queue_gen;

  logic       clk = 1'b0;
  logic       rst, data_in, write_in, dequeue_in;
  logic       consume_en;
  logic       m_status, l_status, m_full, l_full, m_empty, l_empty, m_ovf, l_ovf;
  logic [7:0] m_data, l_data;
  logic [3:0] m_len, l_len;
`ifdef DESER_PARITY_EN
  logic       m_perr, l_perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];   // words in arrival order, first bit = bit 7

  always #5 clk = ~clk;

  deser_queue_gen #(.WORD_W(8), .DEPTH(8), .MSB_FIRST(1)) dut_m (
    .clock_1MHz(clk), .rst(rst), .data_in(data_in), .write_in(write_in),
    .dequeue_in(dequeue_in), .status_out(m_status), .data_out(m_data),
    .len_out(m_len), .full_out(m_full), .empty_out(m_empty), .overflow_out(m_ovf)
`ifdef DESER_PARITY_EN
    , .parity_err_out(m_perr)
`endif
  );

  deser_queue_gen #(.WORD_W(8), .DEPTH(8), .MSB_FIRST(0)) dut_l (
    .clock_1MHz(clk), .rst(rst), .data_in(data_in), .write_in(write_in),
    .dequeue_in(dequeue_in), .status_out(l_status), .data_out(l_data),
    .len_out(l_len), .full_out(l_full), .empty_out(l_empty), .overflow_out(l_ovf)
`ifdef DESER_PARITY_EN
    , .parity_err_out(l_perr)
`endif
  );

  function automatic logic [7:0] bitrev(input logic [7:0] w);
    for (int i = 0; i < 8; i++) bitrev[i] = w[7-i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_both(input string name, input logic [31:0] am, input logic [31:0] al,
                            input logic [31:0] exp);
    check({name, "_msb"}, am, exp);
    check({name, "_lsb"}, al, exp);
  endtask

  // Called at a negedge: compare head with prediction, then pulse dequeue for one cycle.
  task automatic pop_check(input string name);
    logic [7:0] w;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: DUT head 0x%0h with no word expected", name, m_data);
    end else begin
      w = exp_q.pop_front();
      check({name, "_msb"}, m_data, w);
      check({name, "_lsb"}, l_data, bitrev(w));
    end
    dequeue_in = 1'b1;
    @(negedge clk);
    dequeue_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit wait_st, output logic st_after);
    int t;
    t = 0;
    while (wait_st && !m_status && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (wait_st && !m_status) begin
      n_checks++;
      n_fail++;
      $display("FAIL status_wait: status_out still 0 after %0d cycles, required 1", t);
    end
    data_in  = b;
    write_in = 1'b1;
    @(negedge clk);
    st_after = m_status;
    write_in = 1'b0;
    @(negedge clk);
  endtask

  // Prediction is queued before the final strobe so the consumer never sees the word first.
  task automatic send_word(input logic [7:0] w, input bit bad_par, output logic st_last);
    logic st;
    for (int i = 7; i >= 0; i--) begin
`ifndef DESER_PARITY_EN
      if (i == 0 && !bad_par) exp_q.push_back(w);
`endif
      send_bit(w[i], 1'b1, st);
    end
`ifdef DESER_PARITY_EN
    if (!bad_par) exp_q.push_back(w);
    send_bit((^w) ^ bad_par, 1'b1, st);
`endif
    st_last = st;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (consume_en && !m_empty) begin
        pop_check("rand_pop");
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st;
    int   t;
    rst = 1'b1; write_in = 1'b0; data_in = 1'b0; dequeue_in = 1'b0; consume_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_both("rst_status", m_status, l_status, 1);
    check_both("rst_data", m_data, l_data, 0);
    check_both("rst_len", m_len, l_len, 0);
    check_both("rst_full", m_full, l_full, 0);
    check_both("rst_empty", m_empty, l_empty, 1);
    check_both("rst_ovf", m_ovf, l_ovf, 0);
`ifdef DESER_PARITY_EN
    check_both("rst_perr", m_perr, l_perr, 0);
`endif

    // First word 1,0,0,0,0,0,0,0
    send_word(8'h80, 1'b0, st);
    check("first_status_low", st, 0);
    check("first_data_msb", m_data, 8'h80);
    check("first_data_lsb", l_data, 8'h01);
    check_both("first_len", m_len, l_len, 1);
    check_both("first_empty", m_empty, l_empty, 0);
    check("first_status_back", m_status, 1);
    pop_check("first_pop");
    check_both("first_drained", m_empty, l_empty, 1);

    // Fill to full, hold a ninth word, provoke overflow
    for (int k = 0; k < 8; k++) send_word(8'h80 + 8'(k), 1'b0, st);
    check_both("fill_full", m_full, l_full, 1);
    check_both("fill_len", m_len, l_len, 8);
    send_word(8'h88, 1'b0, st);
    check("ninth_status_mid", st, 0);
    check_both("ninth_status", m_status, l_status, 0);
    check_both("ninth_len", m_len, l_len, 8);
    send_bit(1'($urandom_range(0, 1)), 1'b0, st);
    check_both("overflow_set", m_ovf, l_ovf, 1);
    check_both("overflow_len", m_len, l_len, 8);
    pop_check("full_pop");
    check_both("refill_len", m_len, l_len, 8);
    check_both("refill_full", m_full, l_full, 1);
    check("refill_head_msb", m_data, 8'h81);
    check("refill_head_lsb", l_data, 8'h81 == 8'h81 ? bitrev(8'h81) : 8'h00);
    check_both("refill_status", m_status, l_status, 1);
    for (int k = 0; k < 8; k++) pop_check("drain_pop");
    check_both("drain_empty", m_empty, l_empty, 1);
    check_both("drain_len", m_len, l_len, 0);
    check_both("drain_data", m_data, l_data, 0);
    dequeue_in = 1'b1;
    @(negedge clk);
    dequeue_in = 1'b0;
    @(negedge clk);
    check_both("extra_pop_len", m_len, l_len, 0);
    check_both("extra_pop_empty", m_empty, l_empty, 1);

    // Reset mid-word with the strobe held high through release
    for (int k = 0; k < 5; k++) send_bit(1'($urandom_range(0, 1)), 1'b1, st);
    rst = 1'b1; write_in = 1'b1; data_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    write_in = 1'b0;
    @(negedge clk);
    check_both("rst2_ovf", m_ovf, l_ovf, 0);
    check_both("rst2_len", m_len, l_len, 0);
    check_both("rst2_status", m_status, l_status, 1);
    send_word(8'hA5, 1'b0, st);
    check("rst2_data_msb", m_data, 8'hA5);
    check("rst2_data_lsb", l_data, 8'hA5);
    check_both("rst2_word_len", m_len, l_len, 1);
    pop_check("rst2_pop");

`ifdef DESER_PARITY_EN
    send_word(8'hA5, 1'b0, st);
    check_both("par_ok_len", m_len, l_len, 1);
    check_both("par_ok_err", m_perr, l_perr, 0);
    send_word(8'hA5, 1'b1, st);
    check("par_bad_status", st, 1);
    check_both("par_bad_len", m_len, l_len, 1);
    check_both("par_bad_err", m_perr, l_perr, 1);
    pop_check("par_pop");
`endif

    // Random traffic with a concurrent consumer; pointers wrap many times
    consume_en = 1'b1;
    for (int k = 0; k < 48; k++) begin
      send_word(8'($urandom), 1'b0, st);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    t = 0;
    while ((exp_q.size() != 0 || !m_empty) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    consume_en = 1'b0;
    repeat (8) @(negedge clk);
    check("rand_pending", exp_q.size(), 0);
    check_both("rand_empty", m_empty, l_empty, 1);
    check_both("rand_len", m_len, l_len, 0);
    check_both("rand_ovf", m_ovf, l_ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deser_queue_gen.md
# deser_queue_gen

Parametrised serial-to-parallel deserializer with integrated word queue: the next generation of the fixed 8-bit/8-deep deserializer+queue pair. Accepts one bit per rising edge of a strobe, assembles WORD_W-bit words in configurable bit order, pushes them into a DEPTH-entry circular queue and exposes the head word, occupancy and full/empty flags. It throttles the serial producer through `status_out` and records protocol violations in sticky flags. It sits between the slow bit-serial front end and the word consumer, in the 1 MHz domain.

## Interface
- `WORD_W`, 8: word width in bits, ≥2.
- `DEPTH`, 8: queue entries, power of two, ≥2.
- `MSB_FIRST`, 1: 1 = first received bit lands in bit WORD_W-1; 0 = first bit lands in bit 0.
- `clock_1MHz`  in  1  sole clock, rising-edge active.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  1  serial data bit, sampled on the write strobe edge.
- `write_in`  in  1  bit strobe, level; a 0→1 transition captures `data_in`.
- `dequeue_in`  in  1  pop request, level; a 0→1 transition pops one word.
- `status_out`  out  1  1 = deserializer accepts bits.
- `data_out`  out  WORD_W  queue head word; 0 when empty.
- `len_out`  out  $clog2(DEPTH+1)  occupancy, 0..DEPTH.
- `full_out` / `empty_out`  out  1 each  len_out==DEPTH / len_out==0.
- `overflow_out`  out  1  sticky: bit strobe seen while `status_out`=0.
- `parity_err_out`  out  1  sticky parity error (only with DESER_PARITY_EN).

## Operation
- Edge detect: registered copies `write_q`, `deq_q`; edge = input & ~copy. Copies reset to 1, so inputs held high across reset release produce no edge.
- FSM states: COLLECT (shift bits, bit counter 0..WORD_W-1), PARITY (macro only, awaits one parity bit), PUSH (write assembled word), WAIT_SPACE (queue full, word held).
- COLLECT: on write edge, shift `data_in` in per MSB_FIRST, increment counter; on the WORD_W-th bit go to PARITY (macro) or PUSH, counter cleared.
- PUSH: if not full, write `mem[wr_ptr]`, advance wr_ptr (wraps at DEPTH), return to COLLECT; if full, go to WAIT_SPACE.
- WAIT_SPACE: push as soon as full_out deasserts, then COLLECT.
- `status_out` = 1 in COLLECT/PARITY, 0 in PUSH/WAIT_SPACE. Write edges while 0 are dropped and set `overflow_out`.
- Dequeue edge: if not empty, advance rd_ptr (wraps); if empty, ignored, no flag.
- Push and pop in the same cycle: both performed, len_out unchanged; legal at full (pop frees the slot, push still follows next cycle from WAIT_SPACE) and at empty (push lands; pop ignored because the queue was empty at that edge).
- `data_out` = `mem[rd_ptr]` when not empty, else 0; driven from registers only, no input-to-output combinational path.

## Timing
- Reset values: status_out=1, data_out=0, len_out=0, full_out=0, empty_out=1, overflow_out=0, parity_err_out=0; FSM=COLLECT, counter and pointers 0, partial word discarded. Reset mid-word or mid-WAIT_SPACE discards everything.
- Bit capture: `write_in` high at edge N → bit shifted at edge N. Holding the strobe high captures once.
- Word latency: final bit at edge N → PUSH at N+1 → len_out/empty_out/data_out updated after edge N+1. status_out low for exactly cycle N+1 when queue not full.
- Pop: dequeue edge at edge M → len_out decrements and data_out shows next entry after edge M.
- A strobe arriving the cycle after the final bit (status_out=0) is dropped; producers must space strobes ≥2 cycles.

## Configuration
- `DESER_PARITY_EN` defined: after WORD_W data bits, one extra strobed bit is even parity (XOR of data and parity bit must be 0). Match → PUSH. Mismatch → word discarded, `parity_err_out` set (sticky until reset), back to COLLECT, status_out stays 1.
- Undefined: no PARITY state, no `parity_err_out` port; word pushes after WORD_W bits.

## Test plan
- Defaults, MSB_FIRST=1: strobe bits 1,0,0,0,0,0,0,0 → data_out=8'h80, len_out=1, empty_out=0, one cycle after last strobe.
- MSB_FIRST=0: same bit sequence → data_out=8'h01.
- Send 8 words 8'h80..8'h87 → full_out=1, status_out=0 after ninth word completes; ninth word 8'h88 held; extra strobe sets overflow_out=1; one dequeue edge → 8'h88 pushed next cycle, len_out stays 8, data_out=8'h81.
- Dequeue 9 times from full → data_out steps 8'h81..8'h88 then 0, empty_out=1, len_out=0; extra pop ignored; pointers wrap correctly on refill.
- Assert rst after 5 bits, then send 8'hA5 → data_out=8'hA5 (partial bits lost), all sticky flags 0.
- With DESER_PARITY_EN: 8'hA5 + parity 0 → pushed; 8'hA5 + parity 1 → len_out unchanged, parity_err_out=1.
